lustre_fby_n: RTL and testbench

Parametrised Lustre delay operator: `res = init_val -> pre^D next_val`, for N-bit streams and delay depth D. Values advance only on activation instants (`en`), which models Lustre clock conditions. It generalises the single-cycle `lustre_fby` primitive and is instantiated by compiled nodes for multi-step `pre` chains and sub-clocked (`when`) delays. With `D=1` and `en` tied high it is cycle-equivalent to `lustre_fby`.

---
 rtl/lustre_fby_n_pkg.sv | 31 +++
 rtl/lustre_delay_ring.sv | 69 ++++++
 rtl/lustre_fby_n.sv | 86 ++++++++
 tb/tb_lustre_fby_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lustre_fby_n_pkg.sv
// ----------------------------------------------------------------------------
// lustre_fby_n_pkg
//   Types and helpers shared by the depth-D Lustre delay operator and its
//   ring-buffer storage.
//   - upd_e      : which update the operator performs on the next edge,
//                  decoded from the (init, en) pair.
//   - decode_upd : maps init/en onto upd_e. Restart has priority over
//                  activation.
//   - ptr_width  : width of a 0..D-1 pointer (never below 1 bit).
// ----------------------------------------------------------------------------
package lustre_fby_n_pkg;

  typedef enum logic [1:0] {
    UPD_HOLD        = 2'd0,  // !init && !en : nothing moves
    UPD_STEP        = 2'd1,  // !init &&  en : normal activation
    UPD_RESTART_WR  = 2'd2,  //  init &&  en : restart, instant 0 is stored
    UPD_RESTART_CLR = 2'd3   //  init && !en : restart, nothing stored
  } upd_e;

  function automatic upd_e decode_upd(input logic init, input logic en);
    if (init) begin
      return en ? UPD_RESTART_WR : UPD_RESTART_CLR;
    end
    return en ? UPD_STEP : UPD_HOLD;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/lustre_delay_ring.sv
// ----------------------------------------------------------------------------
// lustre_delay_ring
//   N x D ring buffer with a single write pointer. The read port always shows
//   the entry the pointer sits on, which is the oldest stored value once the
//   ring is full; the next write overwrites exactly that entry.
//
//   Ports
//     clock    in  1 : rising-edge clock
//     reset_n  in  1 : asynchronous active-low reset (clears pointer + data)
//     i_upd    in  2 : update selected by the owning operator
//     i_data   in  N : value stored on UPD_STEP / UPD_RESTART_WR
//     o_oldest out N : entry addressed by the write pointer
// ----------------------------------------------------------------------------
module lustre_delay_ring
  import lustre_fby_n_pkg::*;
#(
  parameter int unsigned N = 1,
  parameter int unsigned D = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  upd_e         i_upd,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_oldest
);

  localparam int unsigned     PTR_W = ptr_width(D);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(D - 1);
  // Pointer value after a restart that stored instant 0 into slot 0.
  localparam logic [PTR_W-1:0] FIRST = PTR_W'(1 % D);

  logic [N-1:0]     r_buf [D];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] w_wp_inc;

  // Explicit wrap so non-power-of-two depths never address past D-1.
  always_comb begin
    w_wp_inc = (r_wp == LAST) ? '0 : r_wp + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (i_upd)
        UPD_RESTART_WR: begin
          r_buf[0] <= i_data;
          r_wp     <= FIRST;
        end
        UPD_RESTART_CLR: begin
          r_wp <= '0;
        end
        UPD_STEP: begin
          r_buf[r_wp] <= i_data;
          r_wp        <= w_wp_inc;
        end
        default: begin
          r_wp <= r_wp;
        end
      endcase
    end
  end

  assign o_oldest = r_buf[r_wp];

endmodule

// File: rtl/lustre_fby_n.sv
// ----------------------------------------------------------------------------
// lustre_fby_n
//   Lustre delay operator  res = init_val -> pre^D next_val  for N-bit
//   streams. State only advances on activation instants (en), so the delay
//   counts activations, not cycles. With D=1 and en tied high it is
//   cycle-equivalent to the single-step lustre_fby primitive.
//
//   Ports
//     clock    in  1 : rising-edge clock
//     reset_n  in  1 : asynchronous active-low reset
//     init     in  1 : instant 0 of a (re)started stream
//     en       in  1 : current cycle is an instant of this operator's clock
//     init_val in  N : value delivered for the first D activations
//     next_val in  N : stream being delayed, sampled on activated cycles
//     res      out N : delayed stream (combinational in init/init_val only)
//     primed   out 1 : D activations stored since the last restart
// ----------------------------------------------------------------------------
module lustre_fby_n
  import lustre_fby_n_pkg::*;
#(
  parameter int unsigned N     = 1,
  parameter int unsigned D     = 2,
  parameter int unsigned CNT_W = $clog2(D + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         init,
  input  logic         en,
  input  logic [N-1:0] init_val,
  input  logic [N-1:0] next_val,
  output logic [N-1:0] res,
  output logic         primed
);

  if (N < 1 || D < 1) begin : g_bad_param
    $error("lustre_fby_n: N and D must both be at least 1");
  end

  localparam logic [CNT_W-1:0] FULL = CNT_W'(D);

  upd_e             w_upd;
  logic [N-1:0]     w_oldest;
  logic [CNT_W-1:0] r_fill;
  logic             w_full;

  assign w_upd = decode_upd(init, en);

  lustre_delay_ring #(
    .N (N),
    .D (D)
  ) u_ring (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_upd    (w_upd),
    .i_data   (next_val),
    .o_oldest (w_oldest)
  );

  // Saturating count of activations stored since the last restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= '0;
    end else begin
      case (w_upd)
        UPD_RESTART_WR:  r_fill <= CNT_W'(1);
        UPD_RESTART_CLR: r_fill <= '0;
        UPD_STEP: begin
          if (r_fill != FULL) begin
            r_fill <= r_fill + 1'b1;
          end
        end
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign w_full = (r_fill == FULL);

  // The oldest entry is read before the edge that overwrites it, so the
  // full-ring case needs no write-to-read bypass.
  always_comb begin
    res    = (init || !w_full) ? init_val : w_oldest;
    primed = w_full && !init;
  end

endmodule

// File: tb/tb_lustre_fby_n.sv
// ----------------------------------------------------------------------------
// tb_lustre_fby_n
//   Bench for lustre_fby_n in three configurations: N=1/D=1 toggle node,
//   N=8/D=3 ramp, gap, restart and reset sequences, and N=8/D=5 long random
//   run against a queue model. Inputs change on the falling edge; outputs are
//   sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_lustre_fby_n;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  // D=1 toggle instance
  logic       init1, en1, iv1, res1, pr1;
  logic       nv1;
  assign nv1 = ~res1;

  // D=3 instance
  logic       init3, en3, pr3;
  logic [7:0] iv3, nv3, res3;

  // D=5 instance
  logic       init5, en5, pr5;
  logic [7:0] iv5, nv5, res5;

  lustre_fby_n #(.N(1), .D(1)) u_d1 (
    .clock(clock), .reset_n(reset_n), .init(init1), .en(en1),
    .init_val(iv1), .next_val(nv1), .res(res1), .primed(pr1)
  );

  lustre_fby_n #(.N(8), .D(3)) u_d3 (
    .clock(clock), .reset_n(reset_n), .init(init3), .en(en3),
    .init_val(iv3), .next_val(nv3), .res(res3), .primed(pr3)
  );

  lustre_fby_n #(.N(8), .D(5)) u_d5 (
    .clock(clock), .reset_n(reset_n), .init(init5), .en(en5),
    .init_val(iv5), .next_val(nv5), .res(res5), .primed(pr5)
  );

  typedef struct packed {
    logic       init;
    logic       en;
    logic [7:0] nv;
    logic [7:0] res;
    logic       primed;
  } vec_t;

  typedef struct packed {
    logic [7:0] res;
    logic       primed;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];
  vec_t tbl [19];

  function automatic vec_t mk(input logic i, input logic e, input logic [7:0] n,
                              input logic [7:0] r, input logic p);
    vec_t v;
    v.init = i; v.en = e; v.nv = n; v.res = r; v.primed = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_exp(input string nm, output exp_t e);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got nothing want entry", nm);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // One D=3 cycle: drive at the falling edge, compare 1 ns later.
  task automatic step3(input logic i, input logic e, input logic [7:0] n,
                       input logic [7:0] xres, input logic xpr, input string nm);
    exp_t got;
    @(negedge clock);
    init3 = i; en3 = e; nv3 = n;
    sb.push_back('{res: xres, primed: xpr});
    #1;
    pop_exp(nm, got);
    chk({nm, "_res"}, res3, got.res);
    chk({nm, "_primed"}, {7'd0, pr3}, {7'd0, got.primed});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] hist [$];
    exp_t       got;
    logic       ri, re;
    logic [7:0] rn, xr;

    tbl[0]  = mk(1, 1, 8'd1,  8'hAA, 0);
    tbl[1]  = mk(0, 1, 8'd2,  8'hAA, 0);
    tbl[2]  = mk(0, 1, 8'd3,  8'hAA, 0);
    tbl[3]  = mk(0, 1, 8'd4,  8'd1,  1);
    tbl[4]  = mk(0, 1, 8'd5,  8'd2,  1);
    tbl[5]  = mk(0, 1, 8'd6,  8'd3,  1);
    tbl[6]  = mk(1, 1, 8'd10, 8'hAA, 0);
    tbl[7]  = mk(0, 0, 8'd11, 8'hAA, 0);
    tbl[8]  = mk(0, 0, 8'd12, 8'hAA, 0);
    tbl[9]  = mk(0, 1, 8'd13, 8'hAA, 0);
    tbl[10] = mk(0, 1, 8'd14, 8'hAA, 0);
    tbl[11] = mk(0, 0, 8'd15, 8'd10, 1);
    tbl[12] = mk(0, 1, 8'd16, 8'd10, 1);
    tbl[13] = mk(0, 1, 8'd17, 8'd13, 1);
    tbl[14] = mk(0, 0, 8'd18, 8'd14, 1);
    tbl[15] = mk(0, 1, 8'd19, 8'd14, 1);
    tbl[16] = mk(0, 1, 8'd20, 8'd16, 1);
    tbl[17] = mk(1, 0, 8'd21, 8'hAA, 0);
    tbl[18] = mk(0, 1, 8'd22, 8'hAA, 0);

    reset_n = 1'b0;
    init1 = 0; en1 = 0; iv1 = 0;
    init3 = 0; en3 = 0; iv3 = 8'hAA; nv3 = 0;
    init5 = 0; en5 = 0; iv5 = 8'h5C; nv5 = 0;

    #1;
    chk("rst_d3_res", res3, 8'hAA);
    chk("rst_d3_primed", {7'd0, pr3}, 8'd0);
    chk("rst_d5_res", res5, 8'h5C);
    chk("rst_d5_primed", {7'd0, pr5}, 8'd0);
    #11 reset_n = 1'b1;

    // Toggle node: res = 0 -> pre(not res)
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      init1 = (i == 0); en1 = 1'b1;
      sb.push_back('{res: 8'(i % 2), primed: (i != 0)});
      #1;
      pop_exp("toggle", got);
      chk("toggle_res", {7'd0, res1}, got.res);
      chk("toggle_primed", {7'd0, pr1}, {7'd0, got.primed});
    end
    @(negedge clock);
    en1 = 1'b0;

    // Ramp, sub-clock gaps and init-without-activation
    for (int i = 0; i < 19; i++) begin
      step3(tbl[i].init, tbl[i].en, tbl[i].nv, tbl[i].res, tbl[i].primed,
            $sformatf("tbl%0d", i));
    end

    // Restart mid-stream after 10 activations
    for (int k = 1; k <= 10; k++) begin
      step3(k == 1, 1'b1, 8'(k), (k <= 3) ? 8'hAA : 8'(k - 3), k > 3, "fill10");
    end
    step3(1, 1, 8'd99,  8'hAA, 0, "restart0");
    step3(0, 1, 8'd100, 8'hAA, 0, "restart1");
    step3(0, 1, 8'd101, 8'hAA, 0, "restart2");
    step3(0, 1, 8'd102, 8'd99, 1, "restart3");
    step3(0, 1, 8'd103, 8'd100, 1, "restart4");

    // Asynchronous reset between edges, then refill without init
    @(negedge clock);
    en3 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_res", res3, 8'hAA);
    chk("async_rst_primed", {7'd0, pr3}, 8'd0);
    #9 reset_n = 1'b1;
    step3(0, 1, 8'd50, 8'hAA, 0, "refill0");
    step3(0, 1, 8'd51, 8'hAA, 0, "refill1");
    step3(0, 1, 8'd52, 8'hAA, 0, "refill2");
    step3(0, 1, 8'd53, 8'd50, 1, "refill3");
    step3(0, 0, 8'd54, 8'd51, 1, "refill4");
    @(negedge clock);
    en3 = 1'b0;

    // Long random run on D=5 against a queue of activated values
    hist.delete();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      ri = ($urandom_range(39) == 0);
      re = ($urandom_range(9) < 7);
      rn = 8'($urandom);
      init5 = ri; en5 = re; nv5 = rn; iv5 = 8'($urandom);
      xr = (ri || hist.size() < 5) ? iv5 : hist[0];
      sb.push_back('{res: xr, primed: (!ri && hist.size() == 5)});
      #1;
      pop_exp("wrap", got);
      chk("wrap_res", res5, got.res);
      chk("wrap_primed", {7'd0, pr5}, {7'd0, got.primed});
      @(posedge clock);
      if (re) begin
        if (ri) hist.delete();
        hist.push_back(rn);
        if (hist.size() > 5) void'(hist.pop_front());
      end else if (ri) begin
        hist.delete();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
